// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   - mduop operation codes coming from the control signal decoder
//   - read_hilo select codes
//   - is_muldiv(): true for the four ops that start a timed mult/div
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;
  localparam logic [3:0] MDU_READ  = 4'b1111;

  localparam logic [1:0] HILO_HI = 2'b10;
  localparam logic [1:0] HILO_LO = 2'b01;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational mult/div datapath.
// Ports:
//   op       in  [3:0]  mduop code (MULT/MULTU/DIV/DIVU; others give 0)
//   a, b     in  [31:0] rs / rt operands
//   result   out [63:0] {hi,lo}: product, or {remainder,quotient}
//   div_zero out        DIV/DIVU with b == 0 (result is then meaningless)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        b_zero;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a, mag_b;
  logic [31:0] safe_b, safe_mag_b;
  logic [31:0] q_u, r_u;
  logic [31:0] mq, mr;
  logic [31:0] q_s, r_s;

  assign b_zero = (b == 32'd0);

  // Sign-extend to 64 bits so the low 64 bits of the product are exact.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide done on magnitudes: truncation toward zero falls out
  // naturally, and 0x80000000 / -1 yields quotient 0x80000000, remainder 0
  // without relying on tool-specific overflow behaviour.
  assign mag_a = a[31] ? -a : a;
  assign mag_b = b[31] ? -b : b;

  // A zero divisor is replaced by 1 so the dividers never produce X.
  assign safe_b     = b_zero ? 32'd1 : b;
  assign safe_mag_b = b_zero ? 32'd1 : mag_b;

  assign q_u = a / safe_b;
  assign r_u = a % safe_b;
  assign mq  = mag_a / safe_mag_b;
  assign mr  = mag_a % safe_mag_b;
  assign q_s = (a[31] ^ b[31]) ? -mq : mq;
  assign r_s = a[31] ? -mr : mr;

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        result   = {r_s, q_s};
        div_zero = b_zero;
      end
      MDU_DIVU: begin
        result   = {r_u, q_u};
        div_zero = b_zero;
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning architectural HI/LO.
// The result is computed at accept time and parked in res_*; a countdown
// models the latency and HI/LO take the parked result when it expires.
// Ports:
//   clk        in        rising-edge clock
//   reset      in        asynchronous, active-low clear of all state
//   start      in        begin MULT/MULTU/DIV/DIVU encoded in mduop
//   mduop      in  [3:0] operation code (see mdu_pkg)
//   time_in    in  [3:0] latency in cycles; 0 selects MULT_CYCLES/DIV_CYCLES
//   src_a      in  [31:0] rs operand
//   src_b      in  [31:0] rt operand
//   read_hilo  in  [1:0] 10 = HI, 01 = LO, otherwise 0
//   busy       out       mult/div in flight (to hazard unit)
//   hilo_out   out [31:0] combinational read of architectural HI/LO
//   div0       out       one-cycle pulse after committing a divide by zero
// Optional feature: define MDU_DIV0_FLAG_EN to enable the div0 pulse;
// otherwise div0 is tied to 0.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mduop,
  input  logic [3:0]  time_in,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  read_hilo,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic        div0
);

  localparam logic [3:0] MULT_T = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_T  = 4'(DIV_CYCLES);

  logic [31:0] hi_reg, lo_reg;
  logic [31:0] res_hi_reg, res_lo_reg;
  logic [3:0]  cnt_reg;
  // Pending result came from a zero divisor: skip the HI/LO update at commit.
  logic        discard_reg;

  logic [63:0] arith_result;
  logic        arith_div_zero;
  logic        accept;
  logic        is_div;
  logic [3:0]  load_cnt;
  logic        commit;

  mdu_arith u_arith (
    .op       (mduop),
    .a        (src_a),
    .b        (src_b),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  assign busy     = (cnt_reg != 4'd0);
  assign accept   = start && !busy && is_muldiv(mduop);
  assign is_div   = (mduop == MDU_DIV) || (mduop == MDU_DIVU);
  assign load_cnt = (time_in != 4'd0) ? time_in : (is_div ? DIV_T : MULT_T);
  assign commit   = (cnt_reg == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      res_hi_reg  <= 32'd0;
      res_lo_reg  <= 32'd0;
      cnt_reg     <= 4'd0;
      discard_reg <= 1'b0;
    end else if (accept) begin
      res_hi_reg  <= arith_result[63:32];
      res_lo_reg  <= arith_result[31:0];
      discard_reg <= arith_div_zero;
      cnt_reg     <= load_cnt;
    end else if (busy) begin
      // Any start/MTxx arriving here is ignored; only the countdown runs.
      cnt_reg <= cnt_reg - 4'd1;
      if (commit && !discard_reg) begin
        hi_reg <= res_hi_reg;
        lo_reg <= res_lo_reg;
      end
    end else if (!start && mduop == MDU_MTHI) begin
      hi_reg <= src_a;
    end else if (!start && mduop == MDU_MTLO) begin
      lo_reg <= src_a;
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div0_reg <= 1'b0;
    end else begin
      div0_reg <= commit && discard_reg;
    end
  end

  assign div0 = div0_reg;
`else
  assign div0 = 1'b0;
`endif

  always_comb begin
    case (read_hilo)
      HILO_HI: hilo_out = hi_reg;
      HILO_LO: hilo_out = lo_reg;
      default: hilo_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected results are computed by a
// behavioural model when an op is driven, pushed to a scoreboard queue, and
// popped/compared when busy falls.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mduop;
  logic [3:0]  time_in;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  read_hilo;
  logic        busy;
  logic [31:0] hilo_out;
  logic        div0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    logic        div0;
  } exp_t;

  exp_t sb[$];

  // Model of the architectural HI/LO, updated when a result is popped.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mduop     (mduop),
    .time_in   (time_in),
    .src_a     (src_a),
    .src_b     (src_b),
    .read_hilo (read_hilo),
    .busy      (busy),
    .hilo_out  (hilo_out),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    read_hilo = HILO_HI; #1;
    check_value({tag, "_hi"}, hilo_out, exp_hi);
    read_hilo = HILO_LO; #1;
    check_value({tag, "_lo"}, hilo_out, exp_lo);
    read_hilo = 2'b00; #1;
    check_value({tag, "_none"}, hilo_out, 32'd0);
  endtask

  function automatic exp_t model(input string tag, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] t);
    exp_t        e;
    longint      p;
    logic [63:0] pu;
    int          sa, sb_i;
    e.tag  = tag;
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.div0 = 1'b0;
    if (t != 4'd0) e.cycles = int'(t);
    else e.cycles = (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
    case (op)
      MDU_MULT: begin
        p    = longint'($signed(a)) * longint'($signed(b));
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      MDU_MULTU: begin
        pu   = {32'd0, a} * {32'd0, b};
        e.hi = pu[63:32];
        e.lo = pu[31:0];
      end
      MDU_DIV: begin
        if (b == 32'd0) begin
`ifdef MDU_DIV0_FLAG_EN
          e.div0 = 1'b1;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else begin
          sa   = $signed(a);
          sb_i = $signed(b);
          e.lo = 32'(sa / sb_i);
          e.hi = 32'(sa % sb_i);
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) begin
`ifdef MDU_DIV0_FLAG_EN
          e.div0 = 1'b1;
`endif
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one mult/div, watch busy, then pop and compare at commit.
  // poke: in busy cycle 2, check reads return old HI/LO and fire an illegal start.
  // b2b: return in the first not-busy cycle so the next op is back-to-back.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input bit poke, input bit b2b);
    exp_t        e;
    int          cyc;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    sb.push_back(model(tag, op, a, b, t));
    start   = 1'b1;
    mduop   = op;
    src_a   = a;
    src_b   = b;
    time_in = t;
    tick();
    start = 1'b0;
    mduop = MDU_NONE;
    cyc   = 0;
    while (busy && cyc < 20) begin
      cyc++;
      if (poke && cyc == 2) begin
        read_check({tag, "_busyread"}, old_hi, old_lo);
        start   = 1'b1;
        mduop   = MDU_MULT;
        src_a   = 32'd12345;
        src_b   = 32'd777;
        time_in = 4'd3;
      end
      tick();
      start = 1'b0;
      mduop = MDU_NONE;
    end
    if (sb.size() == 0) begin
      check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_value({e.tag, "_busy_cycles"}, 32'(cyc), 32'(e.cycles));
      check_value({e.tag, "_div0_at_commit"}, {31'd0, div0}, {31'd0, e.div0});
      read_check(e.tag, e.hi, e.lo);
      $display("op %s a=0x%08h b=0x%08h T=%0d busy=%0d hi=0x%08h lo=0x%08h",
               e.tag, a, b, t, cyc, e.hi, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
      if (!b2b) begin
        tick();
        check_value({e.tag, "_div0_after"}, {31'd0, div0}, 32'd0);
        check_value({e.tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] v);
    start = 1'b0;
    mduop = op;
    src_a = v;
    tick();
    mduop = MDU_NONE;
    check_value({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (op == MDU_MTHI) m_hi = v;
    else m_lo = v;
    $display("op %s val=0x%08h", tag, v);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          k;

    reset     = 1'b0;
    start     = 1'b0;
    mduop     = MDU_NONE;
    time_in   = 4'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    read_hilo = 2'b00;

    repeat (2) tick();
    check_value("reset_busy", {31'd0, busy}, 32'd0);
    check_value("reset_div0", {31'd0, div0}, 32'd0);
    read_check("reset", 32'd0, 32'd0);
    reset = 1'b1;
    tick();

    // MULT -7 * 3 using the default latency (time_in = 0 -> 5)
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFF9, 32'd3, 4'd0, 1'b0, 1'b0);
    // DIVU 100 / 7 with explicit T=10
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 4'd10, 1'b0, 1'b0);
    // DIV -7 / 2, default DIV latency
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 4'd0, 1'b0, 1'b0);
    // overflow corner
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3, 1'b0, 1'b0);

    // divide by zero with preloaded HI/LO
    move_to("mthi_11", MDU_MTHI, 32'h11);
    move_to("mtlo_22", MDU_MTLO, 32'h22);
    run_op("div_by0", MDU_DIV, 32'd55, 32'd0, 4'd10, 1'b0, 1'b0);
    run_op("divu_by0", MDU_DIVU, 32'd55, 32'd0, 4'd2, 1'b0, 1'b0);

    // MULTU max*max with reads and an ignored start during busy
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b1, 1'b0);

    // latency boundaries, back-to-back acceptance
    run_op("mult_t1", MDU_MULT, 32'd6, 32'd7, 4'd1, 1'b0, 1'b1);
    run_op("multu_t15", MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 4'd15, 1'b0, 1'b1);
    run_op("divu_b2b", MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 4'd4, 1'b0, 1'b0);

    // MTHI/MTLO ignored while busy
    start   = 1'b1;
    mduop   = MDU_MULT;
    src_a   = 32'd2;
    src_b   = 32'd3;
    time_in = 4'd4;
    tick();
    start = 1'b0;
    mduop = MDU_MTHI;
    src_a = 32'hBAD0_BAD0;
    tick();
    mduop = MDU_NONE;
    repeat (4) tick();
    check_value("mt_busy_ignored_busy", {31'd0, busy}, 32'd0);
    read_check("mt_busy_ignored", 32'd0, 32'd6);
    m_hi = 32'd0;
    m_lo = 32'd6;

    // random ops against the model
    for (int i = 0; i < 6; i++) begin
      k  = $urandom_range(0, 3);
      rop = (k == 0) ? MDU_MULT : (k == 1) ? MDU_MULTU : (k == 2) ? MDU_DIV : MDU_DIVU;
      ra = $urandom();
      rb = $urandom_range(1, 32'h7FFF_FFFF);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op($sformatf("rand%0d", i), rop, ra, rb, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
    end

    // reset asserted in cycle 3 of a DIV
    start   = 1'b1;
    mduop   = MDU_DIV;
    src_a   = 32'd1000;
    src_b   = 32'd3;
    time_in = 4'd10;
    tick();
    start = 1'b0;
    mduop = MDU_NONE;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_value("midreset_busy", {31'd0, busy}, 32'd0);
    read_check("midreset", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    check_value("midreset_late_busy", {31'd0, busy}, 32'd0);
    check_value("midreset_late_div0", {31'd0, div0}, 32'd0);
    read_check("midreset_late", 32'd0, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // MTHI then MTLO in consecutive cycles
    move_to("mthi_dead", MDU_MTHI, 32'hDEAD);
    move_to("mtlo_beef", MDU_MTLO, 32'hBEEF);
    read_check("mt_pair", 32'hDEAD, 32'hBEEF);

    check_value("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
